prover_compute_h_feed: RTL and testbench

Upstream sequencer for the prover's H-accumulation adder. Buffers field elements from the adder tree in a small FIFO and issues them one at a time to the single multi-cycle field adder in the accumulator stage. It waits for each addition to finish before issuing the next element. It drives the running-sum tag (0 on the first element of a group, 1 otherwise) and emits one completed sum per group of `NGROUP` elements.

---
 rtl/prover_compute_h_pkg.sv | 19 +
 rtl/prover_compute_h_feed_fifo.sv | 60 ++++++
 rtl/prover_compute_h_feed.sv | 133 +++++++++++++
 tb/tb_prover_compute_h_feed.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prover_compute_h_pkg.sv
// Shared definitions for the prover_compute_h pipeline stages.
// Holds the field width and the feed sequencer state encoding.
package prover_compute_h_pkg;

   // Field element width; must track the value in field_arith_defs.v.
   localparam int F_NBITS = 64;

   typedef enum logic [1:0] {
      FEED_IDLE  = 2'd0,
      FEED_ISSUE = 2'd1,
      FEED_WAIT  = 2'd2
   } feed_state_t;

   // Counter width for a modulo-n count; a one-value count still needs a bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prover_compute_h_feed_fifo.sv
// Small synchronous FIFO buffering adder-tree outputs for the H feed.
// Head is read combinationally from the storage array so it is ready to issue.
module prover_compute_h_feed_fifo
   import prover_compute_h_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               push,
   input  logic               pop,
   input  logic [F_NBITS-1:0] din,
   output logic [F_NBITS-1:0] dout,
   output logic               empty,
   output logic               full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]      wr_ptr_reg;
   logic [AW-1:0]      rd_ptr_reg;
   logic [AW:0]        count_reg;
   logic [F_NBITS-1:0] mem [DEPTH];
   logic               do_push;
   logic               do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_reg];

   // Storage carries no reset; an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/prover_compute_h_feed.sv
// Issues buffered field elements one at a time to the multi-cycle accumulator
// adder, tags each as start/continue of a running sum, and reports group sums.
module prover_compute_h_feed
   import prover_compute_h_pkg::*;
#(
   parameter int NGROUP = 4,
   parameter int DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               in_valid,
   input  logic [F_NBITS-1:0] in,
   output logic               in_ready,
   output logic               acc_en,
   output logic [F_NBITS-1:0] acc_in,
   output logic               acc_tag,
   input  logic               acc_ready_pulse,
   input  logic [F_NBITS-1:0] acc_out,
   output logic               sum_valid,
   output logic [F_NBITS-1:0] sum_out,
   output logic               overflow
);

   localparam int             GW       = cnt_width(NGROUP);
   localparam logic [GW-1:0]  GRP_LAST = GW'(NGROUP - 1);

   feed_state_t        state_reg, state_next;
   logic [GW-1:0]      grp_cnt_reg, grp_cnt_next;
   logic               acc_en_reg, acc_en_next;
   logic [F_NBITS-1:0] acc_in_reg, acc_in_next;
   logic               acc_tag_reg, acc_tag_next;
   logic               sum_valid_reg, sum_valid_next;
   logic [F_NBITS-1:0] sum_out_reg, sum_out_next;
   logic               overflow_reg, overflow_next;

   logic               fifo_push;
   logic               fifo_pop;
   logic [F_NBITS-1:0] fifo_head;
   logic               fifo_empty;
   logic               fifo_full;
   logic               fifo_avail;

   prover_compute_h_feed_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign fifo_push  = in_valid & ~fifo_full;
   // Work is pending if anything is stored or is being written this cycle.
   assign fifo_avail = ~fifo_empty | fifo_push;

   always_comb begin
      state_next     = state_reg;
      grp_cnt_next   = grp_cnt_reg;
      acc_en_next    = 1'b0;
      acc_in_next    = acc_in_reg;
      acc_tag_next   = acc_tag_reg;
      sum_valid_next = 1'b0;
      sum_out_next   = sum_out_reg;
      fifo_pop       = 1'b0;
      overflow_next  = overflow_reg | (in_valid & fifo_full);

      case (state_reg)
         FEED_IDLE: begin
            if (fifo_avail) begin
               state_next = FEED_ISSUE;
            end
         end
         FEED_ISSUE: begin
            fifo_pop     = 1'b1;
            acc_en_next  = 1'b1;
            acc_in_next  = fifo_head;
            acc_tag_next = (grp_cnt_reg != '0);
            state_next   = FEED_WAIT;
         end
         FEED_WAIT: begin
            // Completions outside WAIT cannot belong to an issued operation.
            if (acc_ready_pulse) begin
               if (grp_cnt_reg == GRP_LAST) begin
                  grp_cnt_next   = '0;
                  sum_valid_next = 1'b1;
                  sum_out_next   = acc_out;
               end else begin
                  grp_cnt_next = grp_cnt_reg + GW'(1);
               end
               state_next = fifo_avail ? FEED_ISSUE : FEED_IDLE;
            end
         end
         default: begin
            state_next = FEED_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_reg     <= FEED_IDLE;
         grp_cnt_reg   <= '0;
         acc_en_reg    <= 1'b0;
         acc_in_reg    <= '0;
         acc_tag_reg   <= 1'b0;
         sum_valid_reg <= 1'b0;
         sum_out_reg   <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         grp_cnt_reg   <= grp_cnt_next;
         acc_en_reg    <= acc_en_next;
         acc_in_reg    <= acc_in_next;
         acc_tag_reg   <= acc_tag_next;
         sum_valid_reg <= sum_valid_next;
         sum_out_reg   <= sum_out_next;
         overflow_reg  <= overflow_next;
      end
   end

   assign in_ready  = ~fifo_full;
   assign acc_en    = acc_en_reg;
   assign acc_in    = acc_in_reg;
   assign acc_tag   = acc_tag_reg;
   assign sum_valid = sum_valid_reg;
   assign sum_out   = sum_out_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_prover_compute_h_feed.sv
// Bench for prover_compute_h_feed: two instances (NGROUP=4 and NGROUP=1), each
// paired with a 3-cycle behavioural accumulator, checked against a queue model.
module tb_prover_compute_h_feed;
   import prover_compute_h_pkg::*;

   localparam int W     = F_NBITS;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rstb = 1'b1;
   logic         in_valid [2] = '{1'b0, 1'b0};
   logic [W-1:0] din [2];
   logic         in_ready [2];
   logic         acc_en [2];
   logic [W-1:0] acc_in [2];
   logic         acc_tag [2];
   logic         acc_ready_pulse [2];
   logic [W-1:0] acc_out [2];
   logic         sum_valid [2];
   logic [W-1:0] sum_out [2];
   logic         overflow [2];

   logic         spur [2] = '{1'b0, 1'b0};
   logic         acc_pulse_m [2] = '{1'b0, 1'b0};
   int           acc_cnt [2];
   logic [W-1:0] acc_res [2];

   prover_compute_h_feed #(.NGROUP(4), .DEPTH(DEPTH)) dut4 (
      .clk(clk), .rstb(rstb), .in_valid(in_valid[0]), .in(din[0]), .in_ready(in_ready[0]),
      .acc_en(acc_en[0]), .acc_in(acc_in[0]), .acc_tag(acc_tag[0]),
      .acc_ready_pulse(acc_ready_pulse[0]), .acc_out(acc_out[0]),
      .sum_valid(sum_valid[0]), .sum_out(sum_out[0]), .overflow(overflow[0])
   );

   prover_compute_h_feed #(.NGROUP(1), .DEPTH(DEPTH)) dut1 (
      .clk(clk), .rstb(rstb), .in_valid(in_valid[1]), .in(din[1]), .in_ready(in_ready[1]),
      .acc_en(acc_en[1]), .acc_in(acc_in[1]), .acc_tag(acc_tag[1]),
      .acc_ready_pulse(acc_ready_pulse[1]), .acc_out(acc_out[1]),
      .sum_valid(sum_valid[1]), .sum_out(sum_out[1]), .overflow(overflow[1])
   );

   assign acc_ready_pulse[0] = acc_pulse_m[0] | spur[0];
   assign acc_ready_pulse[1] = acc_pulse_m[1] | spur[1];

   // Behavioural field adder: result three cycles after acc_en, running sum by tag.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rstb) begin
            acc_cnt[i]     <= 0;
            acc_pulse_m[i] <= 1'b0;
            acc_out[i]     <= '0;
            acc_res[i]     <= '0;
         end else begin
            acc_pulse_m[i] <= (acc_cnt[i] == 1);
            if (acc_cnt[i] == 1) acc_out[i] <= acc_res[i];
            if (acc_en[i] === 1'b1) begin
               acc_cnt[i] <= 2;
               acc_res[i] <= acc_tag[i] ? acc_out[i] + acc_in[i] : acc_in[i];
            end else if (acc_cnt[i] > 0) begin
               acc_cnt[i] <= acc_cnt[i] - 1;
            end
         end
      end
   end

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   // Model state: accepted values, issue/completion positions, pending sums.
   logic [W-1:0] m_vals [2][64];
   int           m_wr [2], m_rd [2], m_due [2], m_ipos [2], m_dpos [2], m_sdue [2];
   bit           m_out [2], m_ovf [2];
   logic [W-1:0] m_gsum [2], m_spend [2], m_shold [2];

   int           tags0[$], tags1[$];
   logic [W-1:0] sums0[$], sums1[$], issued0[$];
   int           done0 = 0, rdy_low0 = 0, en_cnt0 = 0;
   int           exp_tags8 [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

   task automatic chk(input string nm, input int i, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int ng;
      bit e_en;
      bit e_rdy;
      logic [W-1:0] v;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         ng = (i == 0) ? 4 : 1;
         if (rstb) begin
            m_wr[i] = 0; m_rd[i] = 0; m_due[i] = -1; m_ipos[i] = 0; m_dpos[i] = 0;
            m_sdue[i] = -1; m_out[i] = 0; m_ovf[i] = 0;
            m_gsum[i] = '0; m_spend[i] = '0; m_shold[i] = '0;
         end else begin
            e_en = (m_due[i] == cyc);
            chk("acc_en", i, acc_en[i], e_en);
            if (e_en) begin
               v = m_vals[i][m_rd[i] % 64];
               chk("acc_in", i, acc_in[i], v);
               chk("acc_tag", i, acc_tag[i], (m_ipos[i] != 0));
               m_gsum[i] = (m_ipos[i] == 0) ? v : m_gsum[i] + v;
               m_ipos[i] = (m_ipos[i] + 1) % ng;
               m_rd[i]++;
               m_out[i] = 1;
               m_due[i] = -1;
            end
            if (m_sdue[i] == cyc) m_shold[i] = m_spend[i];
            chk("sum_valid", i, sum_valid[i], (m_sdue[i] == cyc));
            chk("sum_out", i, sum_out[i], m_shold[i]);
            e_rdy = (m_wr[i] - m_rd[i]) < DEPTH;
            chk("in_ready", i, in_ready[i], e_rdy);
            chk("overflow", i, overflow[i], m_ovf[i]);
            if (in_valid[i]) begin
               if (e_rdy) begin
                  m_vals[i][m_wr[i] % 64] = din[i];
                  m_wr[i]++;
               end else begin
                  m_ovf[i] = 1;
               end
            end
            if (acc_ready_pulse[i] && m_out[i]) begin
               m_out[i] = 0;
               m_dpos[i]++;
               if (m_dpos[i] == ng) begin
                  m_dpos[i]  = 0;
                  m_spend[i] = m_gsum[i];
                  m_sdue[i]  = cyc + 1;
               end
            end
            if (!m_out[i] && m_due[i] < 0 && m_wr[i] > m_rd[i]) m_due[i] = cyc + 2;
         end
      end
      if (acc_en[0] === 1'b1) begin
         tags0.push_back(int'(acc_tag[0]));
         issued0.push_back(acc_in[0]);
         en_cnt0++;
      end
      if (acc_en[1] === 1'b1) tags1.push_back(int'(acc_tag[1]));
      if (sum_valid[0] === 1'b1) sums0.push_back(sum_out[0]);
      if (sum_valid[1] === 1'b1) sums1.push_back(sum_out[1]);
      if (acc_pulse_m[0] === 1'b1) done0++;
      if (in_ready[0] === 1'b0) rdy_low0++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rstb = 1'b1;
      tick();
      rstb = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", 0, in_ready[0], 1'b1);
      chk("rst_acc_en", 0, acc_en[0], 1'b0);
      chk("rst_acc_in", 0, acc_in[0], '0);
      chk("rst_acc_tag", 0, acc_tag[0], 1'b0);
      chk("rst_sum_valid", 0, sum_valid[0], 1'b0);
      chk("rst_sum_out", 0, sum_out[0], '0);
      chk("rst_overflow", 0, overflow[0], 1'b0);
   endtask

   task automatic chk_tag_seq(input string nm, input int base, input int n);
      chk({nm, "_count"}, 0, tags0.size() - base, n);
      for (int k = 0; k < n; k++)
         chk(nm, 0, (base + k < tags0.size()) ? tags0[base + k] : -1, exp_tags8[k]);
   endtask

   // Pushes one value, idling until the FIFO can take it; leaves in_valid high.
   task automatic push_flow(input int v);
      int n = 0;
      while (in_ready[0] !== 1'b1 && n < 50) begin
         in_valid[0] = 1'b0;
         tick();
         n++;
      end
      in_valid[0] = 1'b1;
      din[0] = W'(v);
      tick();
   endtask

   initial begin
      int bt, bs, r0, d0, be, bad, n;
      din[0] = '0;
      din[1] = '0;
      run(2);
      rstb = 1'b0;
      chk_reset_vals();

      // Four back-to-back pushes form one group.
      bt = tags0.size(); bs = sums0.size(); r0 = rdy_low0;
      for (int k = 1; k <= 4; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      run(40);
      chk_tag_seq("s1_tag", bt, 4);
      chk("s1_nsum", 0, sums0.size() - bs, 1);
      chk("s1_sum", 0, (sums0.size() > bs) ? sums0[bs] : '1, 10);
      chk("s1_ready_low", 0, rdy_low0 - r0, 0);

      // Eight values under backpressure.
      bt = tags0.size(); bs = sums0.size(); r0 = rdy_low0;
      for (int k = 1; k <= 8; k++) push_flow(k);
      in_valid[0] = 1'b0;
      run(80);
      chk_tag_seq("s2_tag", bt, 8);
      chk("s2_nsum", 0, sums0.size() - bs, 2);
      chk("s2_sum0", 0, (sums0.size() > bs) ? sums0[bs] : '1, 10);
      chk("s2_sum1", 0, (sums0.size() > bs + 1) ? sums0[bs + 1] : '1, 26);
      chk("s2_ready_dropped", 0, (rdy_low0 > r0), 1'b1);
      chk("s2_overflow", 0, overflow[0], 1'b0);

      // Six values ignoring in_ready: the sixth hits a full FIFO.
      do_reset();
      bt = issued0.size(); bs = sums0.size();
      for (int k = 11; k <= 16; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      chk("s3_overflow_set", 0, overflow[0], 1'b1);
      run(40);
      chk("s3_overflow_sticky", 0, overflow[0], 1'b1);
      chk("s3_nissued", 0, issued0.size() - bt, 5);
      bad = 0;
      for (int k = bt; k < issued0.size(); k++) if (issued0[k] == 16) bad++;
      chk("s3_dropped_seen", 0, bad, 0);
      chk("s3_sum", 0, (sums0.size() > bs) ? sums0[bs] : '1, 50);

      // Reset after two completions of a four-element group.
      do_reset();
      d0 = done0;
      for (int k = 1; k <= 4; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      n = 0;
      while (done0 < d0 + 2 && n < 60) begin tick(); n++; end
      chk("s4_two_done", 0, (done0 >= d0 + 2), 1'b1);
      rstb = 1'b1;
      tick();
      rstb = 1'b0;
      chk_reset_vals();
      bt = tags0.size(); bs = sums0.size();
      for (int k = 5; k <= 8; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      run(40);
      chk_tag_seq("s4_tag", bt, 4);
      chk("s4_nsum", 0, sums0.size() - bs, 1);
      chk("s4_sum", 0, (sums0.size() > bs) ? sums0[bs] : '1, 26);

      // Spurious completion while idle mid-group.
      bt = tags0.size(); bs = sums0.size();
      for (int k = 1; k <= 2; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      run(30);
      be = en_cnt0;
      spur[0] = 1'b1;
      tick();
      spur[0] = 1'b0;
      run(10);
      chk("s5_no_acc_en", 0, en_cnt0 - be, 0);
      chk("s5_no_sum", 0, sums0.size() - bs, 0);
      for (int k = 3; k <= 4; k++) begin in_valid[0] = 1'b1; din[0] = W'(k); tick(); end
      in_valid[0] = 1'b0;
      run(30);
      chk_tag_seq("s5_tag", bt, 4);
      chk("s5_sum", 0, (sums0.size() > bs) ? sums0[bs] : '1, 10);

      // Single-element groups.
      in_valid[1] = 1'b1; din[1] = W'(7); tick();
      din[1] = W'(9); tick();
      in_valid[1] = 1'b0;
      run(30);
      chk("s6_ntag", 1, tags1.size(), 2);
      for (int k = 0; k < 2; k++) chk("s6_tag", 1, (k < tags1.size()) ? tags1[k] : -1, 0);
      chk("s6_nsum", 1, sums1.size(), 2);
      chk("s6_sum0", 1, (sums1.size() > 0) ? sums1[0] : '1, 7);
      chk("s6_sum1", 1, (sums1.size() > 1) ? sums1[1] : '1, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
